// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM encoding, default tap masks and LFSR step function
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } lfsr_state_e;

    // Widest state the step helper supports; narrower states are zero-extended into it.
    localparam int LFSR_MAX_W = 90;

    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
    localparam logic [89:0] LFSR_TAPS_90 = 90'hF << 86;

    // Feedback enters at the LSB; the caller truncates back to its own width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {state[LFSR_MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - LFSR state register with zero-guarded seed load and single step
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_TAPS_16),
    parameter logic [WIDTH-1:0] SEED_RST = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] next_o
);

    localparam logic [LFSR_MAX_W-1:0] TAPS_EXT = LFSR_MAX_W'(TAPS);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    assign next_o  = WIDTH'(lfsr_step(LFSR_MAX_W'(state_q), TAPS_EXT));
    assign state_o = state_q;

    // A zero seed would park the register forever, so it is replaced by the reset seed.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (load_val_i == '0) ? SEED_RST : load_val_i;
        end else if (step_i) begin
            state_d = next_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED_RST;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/lfsr_stream_gen.sv
// rtl/lfsr_stream_gen.sv - request/response N-step LFSR pattern generator
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_TAPS_16),
    parameter logic [WIDTH-1:0] SEED_RST = '1,
    parameter int               STEP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [WIDTH-1:0]  seed,
    input  logic              req_valid,
    input  logic [STEP_W-1:0] req_steps,
    output logic              req_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              lock_err
);

    lfsr_state_e       state_q, state_d;
    logic [STEP_W-1:0] count_q, count_d;
    logic              lock_err_q, lock_err_d;

    logic              core_load;
    logic              core_step;
    logic [WIDTH-1:0]  core_next;

    lfsr_core #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .SEED_RST (SEED_RST)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (core_load),
        .load_val_i (seed),
        .step_i     (core_step),
        .state_o    (out_data),
        .next_o     (core_next)
    );

    assign req_ready = (state_q == ST_IDLE) && !seed_load;
    assign core_load = (state_q == ST_IDLE) && seed_load;
    assign core_step = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign lock_err  = lock_err_q;

    // Flag rises on the same edge the register falls into the all-zero state.
    assign lock_err_d = lock_err_q | (core_step && (core_next == '0));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    count_d = req_steps;
                    state_d = (req_steps == '0) ? ST_HOLD : ST_RUN;
                end
            end
            ST_RUN: begin
                count_d = count_q - STEP_W'(1);
                if (count_q == STEP_W'(1)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            lock_err_q <= lock_err_d;
        end
    end

endmodule
